// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: opcodes, ALU codes, FSM states and B-immediate helper for instr_sequencer
package instr_seq_pkg;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
  function automatic logic [31:0] b_imm(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/instr_sequencer_decoder.sv
// instr_decoder: combinational R-type/ECALL decode; BEQ accepted only when INSTR_SEQ_BEQ_EN is defined
module instr_decoder
  import instr_seq_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [3:0]  alu,
  output logic        regwrite,
  output logic        is_branch,
  output logic        is_halt,
  output logic        is_illegal
);
  logic [3:0] alu_r;
  logic       legal_r;
  logic       rtype_ok;
  always_comb begin
    alu_r = ALU_ADD;
    legal_r = 1'b1;
    case ({instr[31:25], instr[14:12]})
      {7'h00, 3'b000}: alu_r = ALU_ADD;
      {7'h20, 3'b000}: alu_r = ALU_SUB;
      {7'h00, 3'b111}: alu_r = ALU_AND;
      {7'h00, 3'b110}: alu_r = ALU_OR;
      {7'h00, 3'b100}: alu_r = ALU_XOR;
      {7'h00, 3'b001}: alu_r = ALU_SLL;
      {7'h00, 3'b101}: alu_r = ALU_SRL;
      {7'h00, 3'b010}: alu_r = ALU_SLT;
      default:         legal_r = 1'b0;
    endcase
  end
`ifdef INSTR_SEQ_BEQ_EN
  assign is_branch = instr[6:0] == OP_BRANCH && instr[14:12] == 3'b000;
`else
  assign is_branch = 1'b0;
`endif
  assign rtype_ok   = instr[6:0] == OP_RTYPE && legal_r;
  assign is_halt    = instr == ECALL_WORD;
  assign is_illegal = !is_halt && !rtype_ok && !is_branch;
  assign rs1        = instr[19:15];
  assign rs2        = instr[24:20];
  assign rd         = is_branch ? 5'd0 : instr[11:7];
  assign alu        = is_branch ? ALU_SUB : alu_r;
  assign regwrite   = rtype_ok && instr[11:7] != 5'd0;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/exec control FSM driving the regfile/ALU datapath (BEQ via INSTR_SEQ_BEQ_EN)
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  input  logic               zero_flag,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd,
  output logic [3:0]         alu_control_signal,
  output logic               regwrite_control_signal,
  output logic               busy,
  output logic               halted,
  output logic               illegal
);
  state_t      state, state_nx;
  logic [31:0] pc, ir;
  logic        wr_q, br_q;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [3:0]  d_alu;
  logic        d_wr, d_br, d_halt, d_ill;
  logic        unused_pc;
  instr_decoder u_dec (
    .instr(ir), .rs1(d_rs1), .rs2(d_rs2), .rd(d_rd), .alu(d_alu),
    .regwrite(d_wr), .is_branch(d_br), .is_halt(d_halt), .is_illegal(d_ill)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_HALT: state_nx = start ? S_FETCH : state;
      S_FETCH:        state_nx = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE:       state_nx = (d_halt || d_ill) ? S_HALT : S_EXEC;
      default:        state_nx = S_FETCH;
    endcase
  end
  always_comb begin
    imem_req = state == S_FETCH;
    busy = state == S_FETCH || state == S_DECODE || state == S_EXEC;
    halted = state == S_HALT;
    regwrite_control_signal = state == S_EXEC && wr_q;
  end
  // Datapath fields only move on DECODE->EXEC so they stay put across FETCH and HALT.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= '0;
      ir <= '0;
      rs1 <= '0;
      rs2 <= '0;
      rd <= '0;
      alu_control_signal <= ALU_ADD;
      wr_q <= 1'b0;
      br_q <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if ((state == S_IDLE || state == S_HALT) && start) begin
        pc <= '0;
        illegal <= 1'b0;
      end
      if (state == S_FETCH && imem_ack) ir <= imem_rdata;
      if (state == S_DECODE) begin
        if (d_halt || d_ill) illegal <= d_ill;
        else begin
          rs1 <= d_rs1;
          rs2 <= d_rs2;
          rd <= d_rd;
          alu_control_signal <= d_alu;
          wr_q <= d_wr;
          br_q <= d_br;
        end
      end
      if (state == S_EXEC) pc <= pc + ((br_q && zero_flag) ? b_imm(ir) : 32'd4);
    end
  assign imem_addr = pc[IMEM_AW+1:2];
  assign unused_pc = ^{pc[31:IMEM_AW+2], pc[1:0]};
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench; directed programs, memory responder and decoupled output monitor
module tb_instr_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, imem_ack = 1'b0, zero_flag = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, regwrite_control_signal, busy, halted, illegal;
  logic [7:0]  imem_addr;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_control_signal;
  logic [31:0] mem [0:255];
  typedef struct {int addr; int hold;} fexp_t;
  fexp_t       fq[$];
  logic [18:0] wq[$];
  logic        hq[$];
  int          tests = 0, fails = 0, wait_n = 0, delay_first = 0, req_cnt = 0;
  bit          first = 1'b0, prev_halted = 1'b0;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  instr_sequencer #(.IMEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .zero_flag(zero_flag), .rs1(rs1), .rs2(rs2),
    .rd(rd), .alu_control_signal(alu_control_signal),
    .regwrite_control_signal(regwrite_control_signal), .busy(busy), .halted(halted),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // memory responder: first fetch of a run may be delayed, the rest answer immediately
  always @(negedge clk) begin
    if (!rst_n || !imem_req) begin
      imem_ack = 1'b0;
      wait_n = 0;
    end else if (wait_n >= (first ? delay_first : 0)) begin
      imem_ack = 1'b1;
      imem_rdata = mem[imem_addr];
      wait_n = 0;
      first = 1'b0;
    end else begin
      imem_ack = 1'b0;
      wait_n++;
    end
  end

  always @(negedge clk) begin
    fexp_t       f;
    logic [18:0] w;
    #1;
    if (!rst_n) begin
      req_cnt = 0;
      prev_halted = 1'b0;
    end else begin
      if (imem_req) req_cnt++;
      if (imem_req && imem_ack) begin
        if (fq.size() == 0) begin
          tests++; fails++;
          $display("FAIL fetch_unexpected: got addr %0h expected none", imem_addr);
        end else begin
          f = fq.pop_front();
          chk("fetch_addr", imem_addr, f.addr);
          if (f.hold != 0) chk("req_hold_cycles", req_cnt, f.hold);
        end
        req_cnt = 0;
      end
      if (!imem_req) req_cnt = 0;
      if (regwrite_control_signal) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL write_unexpected: got rd %0d expected no write", rd);
        end else begin
          w = wq.pop_front();
          chk("wr_rs1", rs1, w[18:14]);
          chk("wr_rs2", rs2, w[13:9]);
          chk("wr_rd", rd, w[8:4]);
          chk("wr_alu", alu_control_signal, w[3:0]);
        end
      end
      if (halted && !prev_halted) begin
        if (hq.size() == 0) begin
          tests++; fails++;
          $display("FAIL halt_unexpected: got illegal %0b expected no halt", illegal);
        end else chk("halt_illegal", illegal, hq.pop_front());
        chk("halt_busy", busy, 0);
      end
      prev_halted = halted;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic pf(int a, int h);
    fq.push_back('{a, h});
  endtask

  task automatic pw(int r1, int r2, int d, logic [3:0] alu);
    wq.push_back({r1[4:0], r2[4:0], d[4:0], alu});
  endtask

  task automatic run_prog(int dly);
    delay_first = dly;
    first = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60 && !halted; i++) @(negedge clk);
    if (!halted) begin
      tests++; fails++;
      $display("FAIL halt_timeout: got halted 0 expected 1");
    end
    repeat (2) @(negedge clk);
    chk("fetch_q_left", fq.size(), 0);
    chk("write_q_left", wq.size(), 0);
    chk("halt_q_left", hq.size(), 0);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_rs1"}, rs1, 0);
    chk({tag, "_rs2"}, rs2, 0);
    chk({tag, "_rd"}, rd, 0);
    chk({tag, "_alu"}, alu_control_signal, 4'b0010);
    chk({tag, "_wr"}, regwrite_control_signal, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_illegal"}, illegal, 0);
  endtask

  initial begin
    clear_mem();
    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    // ADD x4,x2,x1 ; ECALL with zero-wait memory
    mem[0] = 32'h0011_0233; mem[1] = ECALL;
    pf(0, 1); pf(1, 0); pw(2, 1, 4, 4'b0010); hq.push_back(1'b0);
    run_prog(0);
    chk("ecall_halted", halted, 1);

    // same program, first ack two cycles late
    pf(0, 3); pf(1, 1); pw(2, 1, 4, 4'b0010); hq.push_back(1'b0);
    run_prog(2);

    // SUB x5,x7,x3 ; illegal 0x7F
    clear_mem();
    mem[0] = 32'h4033_82B3; mem[1] = 32'h0000_007F;
    pf(0, 0); pf(1, 0); pw(7, 3, 5, 4'b0110); hq.push_back(1'b1);
    run_prog(0);
    chk("illegal_hold_alu", alu_control_signal, 4'b0110);
    chk("illegal_hold_rd", rd, 5);

    // ADD x0,x1,x2 ; ECALL -> no write, still advances
    clear_mem();
    mem[0] = 32'h0020_8033; mem[1] = ECALL;
    pf(0, 0); pf(1, 0); hq.push_back(1'b0);
    run_prog(0);
    chk("x0_illegal_cleared", illegal, 0);
    chk("x0_rs1", rs1, 1);
    chk("x0_rs2", rs2, 2);
    chk("x0_rd", rd, 0);

    // OR x6,x1,x2 ; SLT x7,x1,x2 ; funct7=0100000/funct3=110 is illegal
    clear_mem();
    mem[0] = 32'h0020_E333; mem[1] = 32'h0020_A3B3; mem[2] = 32'h4020_E333;
    pf(0, 0); pf(1, 0); pf(2, 0);
    pw(1, 2, 6, 4'b0001); pw(1, 2, 7, 4'b0111); hq.push_back(1'b1);
    run_prog(0);

    // BEQ x1,x1,+8
    clear_mem();
    mem[0] = 32'h0010_8463; mem[1] = ECALL; mem[2] = ECALL;
`ifdef INSTR_SEQ_BEQ_EN
    zero_flag = 1'b1;
    pf(0, 0); pf(2, 0); hq.push_back(1'b0);
    run_prog(0);
    zero_flag = 1'b0;
    pf(0, 0); pf(1, 0); hq.push_back(1'b0);
    run_prog(0);
`else
    pf(0, 0); hq.push_back(1'b1);
    run_prog(0);
`endif

    // asynchronous reset during EXEC of an ADD
    clear_mem();
    mem[0] = 32'h0011_0233; mem[1] = ECALL;
    pf(0, 0); pw(2, 1, 4, 4'b0010);
    delay_first = 0;
    first = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !regwrite_control_signal; i++) begin
      @(negedge clk);
      #1;
    end
    chk("pre_reset_wr", regwrite_control_signal, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    pf(0, 0); pf(1, 0); pw(2, 1, 4, 4'b0010); hq.push_back(1'b0);
    run_prog(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
